// File: rtl/led_chaser_ctrl.sv
// led_chaser_ctrl
//   Running-light sequencer that drives a registered LED decoder. It produces
//   the LED index and the decoder enable code. An enable of 3'd4 lights one
//   LED and 3'd0 blanks all of them.
//   The lit position steps once every TICK_DIV clocks. Two modes exist:
//   wrap (7->0 / 0->7) and bounce (reverse at either end).
//   The sequence has start, pause (HOLD) and stop control.
//
//   Optional build macro: CHASER_BLINK_EN
//     When defined, enable toggles 4/0 every TICK_DIV cycles while in HOLD.
//     It starts at 4 when HOLD is entered.
//
// Parameters
//   TICK_DIV  clock cycles per position step, 1..255
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   start   in   start / resume (level)
//   stop    in   pause / end (level); wins over start
//   dir     in   initial direction, 0 = up, 1 = down (latched on IDLE->RUN)
//   mode    in   0 = wrap, 1 = bounce (latched on IDLE->RUN)
//   switch  out  [2:0] LED index
//   enable  out  [2:0] decoder enable (4 = display, 0 = blank)
//   busy    out  high in RUN and HOLD
//   wrap    out  one-cycle pulse with the position after a wrap/reversal
module led_chaser_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       mode,
  output logic [2:0] switch,
  output logic [2:0] enable,
  output logic       busy,
  output logic       wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  localparam logic [7:0] TC = 8'(TICK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_presc;
  logic       r_dir;
  logic       r_mode;
  logic [2:0] r_switch;
  logic [2:0] r_enable;
  logic       r_busy;
  logic       r_wrap;

  logic       w_at_end;
  logic       w_next_dir;
  logic [2:0] w_next_switch;

  // Next position for one step. In wrap mode, the 3-bit increment and
  // decrement roll over naturally at each end.
  always_comb begin
    w_at_end      = r_dir ? (r_switch == 3'd0) : (r_switch == 3'd7);
    w_next_dir    = r_dir;
    w_next_switch = r_dir ? (r_switch - 3'd1) : (r_switch + 3'd1);
    if (w_at_end && r_mode) begin
      w_next_dir    = ~r_dir;
      w_next_switch = r_dir ? 3'd1 : 3'd6;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_dir    <= 1'b0;
      r_mode   <= 1'b0;
      r_switch <= '0;
      r_enable <= '0;
      r_busy   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state  <= S_RUN;
            r_switch <= dir ? 3'd7 : 3'd0;
            r_enable <= 3'd4;
            r_busy   <= 1'b1;
            r_presc  <= '0;
            r_dir    <= dir;
            r_mode   <= mode;
          end
        end
        S_RUN: begin
          if (stop) begin
            // A step that falls due on this edge is dropped.
            r_state <= S_HOLD;
            r_presc <= '0;
          end else if (r_presc == TC) begin
            r_presc  <= '0;
            r_switch <= w_next_switch;
            r_dir    <= w_next_dir;
            r_wrap   <= w_at_end;
          end else begin
            r_presc <= r_presc + 8'd1;
          end
        end
        S_HOLD: begin
          if (stop) begin
            r_state  <= S_IDLE;
            r_switch <= '0;
            r_enable <= '0;
            r_busy   <= 1'b0;
            r_presc  <= '0;
          end else if (start) begin
            r_state  <= S_RUN;
            r_presc  <= '0;
            r_enable <= 3'd4;
          end else begin
`ifdef CHASER_BLINK_EN
            // The prescaler is idle in HOLD, so it paces the blink.
            if (r_presc == TC) begin
              r_presc  <= '0;
              r_enable <= r_enable ^ 3'd4;
            end else begin
              r_presc <= r_presc + 8'd1;
            end
`else
            r_enable <= 3'd4;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign switch = r_switch;
  assign enable = r_enable;
  assign busy   = r_busy;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
module tb_led_chaser_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic dir = 1'b0;
  logic mode = 1'b0;

  logic [2:0] sw4, en4, sw1, en1;
  logic       busy4, wrap4, busy1, wrap1;

  led_chaser_ctrl #(.TICK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .switch(sw4), .enable(en4), .busy(busy4), .wrap(wrap4)
  );

  led_chaser_ctrl #(.TICK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .switch(sw1), .enable(en1), .busy(busy1), .wrap(wrap1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It keeps a position, a signed step of +1/-1, and the
  // number of cycles since the last (re)start. Index 0 models TICK_DIV=4 and
  // index 1 models TICK_DIV=1. State values: 0 idle, 1 run, 2 hold.
  int m_div[2] = '{4, 1};
  int m_st[2], m_pos[2], m_s[2], m_cnt[2], m_hc[2];
  bit m_bounce[2], m_wrap[2];

  task automatic m_reset(input int k);
    m_st[k] = 0; m_pos[k] = 0; m_s[k] = 1; m_cnt[k] = 0; m_hc[k] = 0;
    m_bounce[k] = 0; m_wrap[k] = 0;
  endtask

  task automatic m_step(input int k);
    int n;
    n = m_pos[k] + m_s[k];
    if (n < 0 || n > 7) begin
      m_wrap[k] = 1;
      if (m_bounce[k]) begin
        m_s[k] = -m_s[k];
        n = m_pos[k] + m_s[k];
      end else begin
        n = (n + 8) % 8;
      end
    end
    m_pos[k] = n;
  endtask

  task automatic m_edge(input int k);
    m_wrap[k] = 0;
    case (m_st[k])
      0: if (start && !stop) begin
        m_st[k] = 1;
        m_pos[k] = dir ? 7 : 0;
        m_s[k] = dir ? -1 : 1;
        m_bounce[k] = mode;
        m_cnt[k] = 0;
      end
      1: if (stop) begin
        m_st[k] = 2;
        m_hc[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] % m_div[k] == 0) m_step(k);
      end
      default: if (stop) begin
        m_st[k] = 0;
        m_pos[k] = 0;
      end else if (start) begin
        m_st[k] = 1;
        m_cnt[k] = 0;
      end else begin
        m_hc[k]++;
      end
    endcase
  endtask

  function automatic int m_switch(input int k);
    return (m_st[k] == 0) ? 0 : m_pos[k];
  endfunction

  function automatic int m_enable(input int k);
    if (m_st[k] == 0) return 0;
`ifdef CHASER_BLINK_EN
    if (m_st[k] == 2 && ((m_hc[k] / m_div[k]) % 2) == 1) return 0;
`endif
    return 4;
  endfunction

  initial begin
    m_reset(0);
    m_reset(1);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) m_reset(k);
      else m_edge(k);
    end
  end

  always @(negedge rst) begin
    for (int k = 0; k < 2; k++) m_reset(k);
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    chk("div4.switch", int'(sw4), m_switch(0));
    chk("div4.enable", int'(en4), m_enable(0));
    chk("div4.busy", int'(busy4), int'(m_st[0] != 0));
    chk("div4.wrap", int'(wrap4), int'(m_wrap[0]));
    chk("div1.switch", int'(sw1), m_switch(1));
    chk("div1.enable", int'(en1), m_enable(1));
    chk("div1.busy", int'(busy1), int'(m_st[1] != 0));
    chk("div1.wrap", int'(wrap1), int'(m_wrap[1]));
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.switch", int'(sw4), 0);
    chk("rst.enable", int'(en4), 0);
    chk("rst.busy", int'(busy4), 0);
    chk("rst.wrap", int'(wrap4), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.busy", int'(busy4), 0);

    // Wrap up, TICK_DIV=4
    dir = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wrapup.first", int'(sw4), 0);
    chk("wrapup.enable", int'(en4), 4);
    chk("wrapup.busy", int'(busy4), 1);
    repeat (3) @(negedge clk);
    chk("wrapup.hold4", int'(sw4), 0);
    repeat (25) @(negedge clk);
    chk("wrapup.at7", int'(sw4), 7);
    chk("wrapup.nowrap", int'(wrap4), 0);
    repeat (4) @(negedge clk);
    chk("wrapup.back0", int'(sw4), 0);
    chk("wrapup.pulse", int'(wrap4), 1);
    @(negedge clk);
    chk("wrapup.pulse_end", int'(wrap4), 0);

    // Double stop: RUN -> HOLD -> IDLE
    stop = 1'b1;
    @(negedge clk);
    chk("dstop.hold_busy", int'(busy4), 1);
    chk("dstop.hold_en", int'(en4), 4);
    @(negedge clk);
    stop = 1'b0;
    chk("dstop.idle_sw", int'(sw4), 0);
    chk("dstop.idle_en", int'(en4), 0);
    chk("dstop.idle_busy", int'(busy4), 0);

    // Bounce down, TICK_DIV=1
    dir = 1'b1; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bounce.first", int'(sw1), 7);
    repeat (7) @(negedge clk);
    chk("bounce.at0", int'(sw1), 0);
    chk("bounce.nowrap", int'(wrap1), 0);
    @(negedge clk);
    chk("bounce.rev", int'(sw1), 1);
    chk("bounce.pulse", int'(wrap1), 1);
    @(negedge clk);
    chk("bounce.next", int'(sw1), 2);
    chk("bounce.pulse_end", int'(wrap1), 0);
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;

    // Priority in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("prio.idle_en", int'(en4), 0);
    chk("prio.idle_busy", int'(busy4), 0);

    // Pause at 3 mid-prescale, then resume, TICK_DIV=4
    dir = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pause.pre", int'(sw4), 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("pause.sw", int'(sw4), 3);
    chk("pause.en", int'(en4), 4);
    repeat (5) @(negedge clk);
    chk("pause.sw_late", int'(sw4), 3);
`ifdef CHASER_BLINK_EN
    chk("pause.blink", int'(en4), 0);
`else
    chk("pause.steady", int'(en4), 4);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume.sw", int'(sw4), 3);
    chk("resume.en", int'(en4), 4);
    repeat (3) @(negedge clk);
    chk("resume.wait", int'(sw4), 3);
    @(negedge clk);
    chk("resume.step", int'(sw4), 4);

    // Priority in RUN
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("prio.run_busy", int'(busy4), 1);
    chk("prio.run_sw", int'(sw4), 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Async reset mid-RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst.sw4", int'(sw4), 0);
    chk("arst.en4", int'(en4), 0);
    chk("arst.busy4", int'(busy4), 0);
    chk("arst.sw1", int'(sw1), 0);
    chk("arst.en1", int'(en1), 0);
    chk("arst.busy1", int'(busy1), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst.stay_idle_en", int'(en4), 0);
    chk("arst.stay_idle_busy", int'(busy1), 0);

    // Randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      dir   = 1'($urandom_range(0, 1));
      mode  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    start = 1'b0;
    stop = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
